// File: rtl/divconv_pkg.sv
// Shared types and constants for the divconv control sequencer.
package divconv_pkg;

  localparam int unsigned ITER_CNT_W = 4;

  localparam logic [1:0] SEL_A_INIT    = 2'b10;
  localparam logic [1:0] SEL_A_ITER    = 2'b00;
  localparam logic [1:0] SEL_B_INIT    = 2'b00;
  localparam logic [1:0] SEL_B_ITER_B  = 2'b10;
  localparam logic [1:0] SEL_B_ITER_AC = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StInitBSetup,
    StInitBLoad,
    StInitAcSetup,
    StInitAcLoad,
    StIterBSetup,
    StIterBLoad,
    StIterAcSetup,
    StIterAcLoad,
    StDone
  } divconv_state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] sel_muxa;
    logic [1:0] sel_muxb;
    logic       load_rega;
    logic       load_regb;
    logic       load_regc;
  } divconv_ctrl_t;

  // Output word for the cycle spent in state s; Setup and Load share selects.
  function automatic divconv_ctrl_t ctrl_decode(divconv_state_t s);
    divconv_ctrl_t c;
    c = '0;
    case (s)
      StInitBSetup, StInitBLoad: begin
        c.busy      = 1'b1;
        c.sel_muxa  = SEL_A_INIT;
        c.sel_muxb  = SEL_B_INIT;
        c.load_regb = (s == StInitBLoad);
      end
      StInitAcSetup, StInitAcLoad: begin
        c.busy      = 1'b1;
        c.sel_muxa  = SEL_A_INIT;
        c.sel_muxb  = SEL_B_INIT;
        c.load_rega = (s == StInitAcLoad);
        c.load_regc = (s == StInitAcLoad);
      end
      StIterBSetup, StIterBLoad: begin
        c.busy      = 1'b1;
        c.sel_muxa  = SEL_A_ITER;
        c.sel_muxb  = SEL_B_ITER_B;
        c.load_regb = (s == StIterBLoad);
      end
      StIterAcSetup, StIterAcLoad: begin
        c.busy      = 1'b1;
        c.sel_muxa  = SEL_A_ITER;
        c.sel_muxb  = SEL_B_ITER_AC;
        c.load_rega = (s == StIterAcLoad);
        c.load_regc = (s == StIterAcLoad);
      end
      StDone:  c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/divconv_ctrl.sv
// Control sequencer for the divconv convergence divider: init step, then ITERATIONS refinements.
// Optional abort input when DIVCONV_CTRL_ABORT_EN is defined.
module divconv_ctrl
  import divconv_pkg::*;
#(
  parameter int unsigned ITERATIONS = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
`ifdef DIVCONV_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       load_rega,
  output logic       load_regb,
  output logic       load_regc
);

  if (ITERATIONS < 1 || ITERATIONS > 15) begin : gen_iter_check
    $error("divconv_ctrl: ITERATIONS must be in 1..15");
  end

  localparam logic [ITER_CNT_W-1:0] LastIter = ITER_CNT_W'(ITERATIONS - 1);

  divconv_state_t          state_q, state_d;
  logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
  divconv_ctrl_t           ctrl_q;
  logic                    abort_req;

`ifdef DIVCONV_CTRL_ABORT_EN
  assign abort_req = abort & ctrl_q.busy;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:        if (start) state_d = StInitBSetup;
      StInitBSetup:  state_d = StInitBLoad;
      StInitBLoad:   state_d = StInitAcSetup;
      StInitAcSetup: state_d = StInitAcLoad;
      StInitAcLoad: begin
        state_d = StIterBSetup;
        cnt_d   = '0;
      end
      StIterBSetup:  state_d = StIterBLoad;
      StIterBLoad:   state_d = StIterAcSetup;
      StIterAcSetup: state_d = StIterAcLoad;
      StIterAcLoad: begin
        cnt_d   = cnt_q + ITER_CNT_W'(1);
        state_d = (cnt_q == LastIter) ? StDone : StIterBSetup;
      end
      StDone:        state_d = start ? StInitBSetup : StIdle;
      default:       state_d = StIdle;
    endcase
    if (abort_req) state_d = StIdle;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign sel_muxa  = ctrl_q.sel_muxa;
  assign sel_muxb  = ctrl_q.sel_muxb;
  assign load_rega = ctrl_q.load_rega;
  assign load_regb = ctrl_q.load_regb;
  assign load_regc = ctrl_q.load_regc;

endmodule

// File: tb/tb_divconv_ctrl.sv
// Scoreboard bench for divconv_ctrl: accepted starts push the expected per-cycle output trace.
module tb_divconv_ctrl;

  localparam int unsigned ITER = 2;

  logic       Clk;
  logic       Rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] sel_muxa;
  logic [1:0] sel_muxb;
  logic       load_rega;
  logic       load_regb;
  logic       load_regc;

  divconv_ctrl #(
    .ITERATIONS(ITER)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
`ifdef DIVCONV_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sel_muxa  (sel_muxa),
    .sel_muxb  (sel_muxb),
    .load_rega (load_rega),
    .load_regb (load_regb),
    .load_regc (load_regc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Vector layout: {busy, done, sel_muxa, sel_muxb, load_rega, load_regb, load_regc}
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  int         n_cmp;
  int         n_err;
  int         cyc;
  int         n_done_obs;
  int         n_done_exp;
  int         done_mark;

  function automatic logic [8:0] vec(input logic b, input logic d, input logic [1:0] a,
                                     input logic [1:0] bs, input logic la, input logic lb,
                                     input logic lc);
    return {b, d, a, bs, la, lb, lc};
  endfunction

  task automatic push_seq();
    exp_q.push_back(vec(1, 0, 2'b10, 2'b00, 0, 0, 0));
    exp_q.push_back(vec(1, 0, 2'b10, 2'b00, 0, 1, 0));
    exp_q.push_back(vec(1, 0, 2'b10, 2'b00, 0, 0, 0));
    exp_q.push_back(vec(1, 0, 2'b10, 2'b00, 1, 0, 1));
    for (int i = 0; i < int'(ITER); i++) begin
      exp_q.push_back(vec(1, 0, 2'b00, 2'b10, 0, 0, 0));
      exp_q.push_back(vec(1, 0, 2'b00, 2'b10, 0, 1, 0));
      exp_q.push_back(vec(1, 0, 2'b00, 2'b11, 0, 0, 0));
      exp_q.push_back(vec(1, 0, 2'b00, 2'b11, 1, 0, 1));
    end
    exp_q.push_back(vec(0, 1, 2'b00, 2'b00, 0, 0, 0));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive, apply the model at the edge, then compare #1 after it.
  task automatic step(input logic st, input logic rn, input logic ab, input string tag);
    logic [8:0] exp;
    logic [8:0] obs;
    start = st;
    Rst_n = rn;
    abort = ab;
    @(posedge Clk);
    if (!rn) exp_q.delete();
    else if (ab && last_exp[8]) exp_q.delete();
    else if (st && !last_exp[8]) push_seq();
    #1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'b0;
    obs = {busy, done, sel_muxa, sel_muxb, load_rega, load_regb, load_regc};
    check(tag, 32'(obs), 32'(exp));
    if (obs[7] === 1'b1) n_done_obs++;
    if (exp[7]) n_done_exp++;
    last_exp = exp;
    cyc++;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_done_obs = 0; n_done_exp = 0;
    last_exp = '0;
    start = 1'b0; Rst_n = 1'b0; abort = 1'b0;

    // Reset with random start.
    for (int i = 0; i < 2; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, "reset");
    step(1'b0, 1'b1, 1'b0, "idle");

    // Nominal single sequence; done expected 13 cycles after start.
    step(1'b1, 1'b1, 1'b0, "nominal");
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, "nominal");

    // Start pulses while busy must be ignored.
    done_mark = n_done_obs;
    step(1'b1, 1'b1, 1'b0, "busy_ign");
    for (int i = 0; i < 12; i++) step(1'(i % 3 == 0), 1'b1, 1'b0, "busy_ign");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "busy_ign");
    check("one_done_per_start", 32'(n_done_obs - done_mark), 32'd1);

    // Start held high: back-to-back sequences.
    done_mark = n_done_obs;
    for (int i = 0; i < 39; i++) step(1'b1, 1'b1, 1'b0, "b2b");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, "b2b_drain");
    check("b2b_dones", 32'(n_done_obs - done_mark), 32'd3);

    // Reset mid-sequence: no done.
    done_mark = n_done_obs;
    step(1'b1, 1'b1, 1'b0, "mid_rst");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "mid_rst");
    step(1'b0, 1'b0, 1'b0, "mid_rst_edge");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, "mid_rst_after");
    check("mid_rst_no_done", 32'(n_done_obs - done_mark), 32'd0);

`ifdef DIVCONV_CTRL_ABORT_EN
    done_mark = n_done_obs;
    step(1'b1, 1'b1, 1'b0, "abort");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "abort");
    step(1'b0, 1'b1, 1'b1, "abort_edge");
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, "abort_after");
    check("abort_no_done", 32'(n_done_obs - done_mark), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "abort_idle");
    step(1'b1, 1'b1, 1'b1, "abort_idle_start");
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, "abort_idle_run");
`endif

    check("total_dones", 32'(n_done_obs), 32'(n_done_exp));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
